// File: rtl/char_bound_extractor_if.sv
// Bundle of the pixel AXI-Stream input and the reorder-block bound write port
// used by char_bound_extractor. "slave" is the extractor's view (it accepts
// pixels and drives bound writes); "master" is the upstream/downstream view.
interface char_bound_extractor_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 8
);
  localparam int STRB_W = (C_S_AXIS_TDATA_WIDTH / 8 > 0) ? C_S_AXIS_TDATA_WIDTH / 8 : 1;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [STRB_W-1:0]               s_axis_tstrb;
  logic                            s_axis_tvalid;
  logic                            s_axis_tready;
  logic                            s_axis_tlast;
  logic                            s_axis_tuser;

  logic [2:0]  bound_x_min_addr;
  logic [15:0] bound_x_min;
  logic        bound_x_min_we;
  logic [2:0]  bound_x_max_addr;
  logic [15:0] bound_x_max;
  logic        bound_x_max_we;
  logic [15:0] bound_y_min;
  logic        bound_y_min_we;
  logic [15:0] bound_y_max;
  logic        bound_y_max_we;

  logic [3:0]  seg_count;
  logic        seg_overflow;
  logic        frame_done;

  modport slave (
    input  s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output bound_x_min_addr, bound_x_min, bound_x_min_we,
    output bound_x_max_addr, bound_x_max, bound_x_max_we,
    output bound_y_min, bound_y_min_we, bound_y_max, bound_y_max_we,
    output seg_count, seg_overflow, frame_done
  );

  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  bound_x_min_addr, bound_x_min, bound_x_min_we,
    input  bound_x_max_addr, bound_x_max, bound_x_max_we,
    input  bound_y_min, bound_y_min_we, bound_y_max, bound_y_max_we,
    input  seg_count, seg_overflow, frame_done
  );
endinterface

// File: rtl/char_bound_extractor.sv
// Character bound extractor: accumulates column/row foreground projections of
// a binarized plate frame, then scans the column projection for character runs
// and writes up to 8 x-bound pairs plus one y-bound pair into the reorder block.
// Optional feature macro: SEG_MIN_WIDTH_EN drops runs narrower than
// MIN_CHAR_WIDTH columns.
module char_bound_extractor #(
  parameter int NUMBER_OF_COLS       = 640,
  parameter int NUMBER_OF_ROWS       = 480,
  parameter int C_S_AXIS_TDATA_WIDTH = 8,
  parameter int COL_THRESH           = 2,
  parameter int ROW_THRESH           = 4,
  parameter int MIN_CHAR_WIDTH       = 3
) (
  input logic                    aclk,
  input logic                    areset,
  char_bound_extractor_if.slave  bus
);

  localparam int CW  = (NUMBER_OF_COLS > 1) ? $clog2(NUMBER_OF_COLS) : 1;
  localparam int RW  = (NUMBER_OF_ROWS > 1) ? $clog2(NUMBER_OF_ROWS) : 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0]  LAST_COL = CW'(NUMBER_OF_COLS - 1);
  localparam logic [RW-1:0]  LAST_ROW = RW'(NUMBER_OF_ROWS - 1);
  localparam logic [15:0]    COL_TH   = 16'(COL_THRESH);
  localparam logic [15:0]    ROW_TH   = 16'(ROW_THRESH);
  localparam logic [CW1-1:0] MIN_W    = CW1'(MIN_CHAR_WIDTH);

`ifdef SEG_MIN_WIDTH_EN
  localparam bit MIN_W_EN = 1'b1;
`else
  localparam bit MIN_W_EN = 1'b0;
`endif

  typedef enum logic [2:0] {CLEAR, ACCUM, SCAN, WR_MIN, WR_MAX, WR_Y} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] a, input logic b);
    if (b && (a != 16'hFFFF)) return a + 16'd1;
    return a;
  endfunction

  // Control state
  state_t        state;
  logic [CW-1:0] clr_addr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [15:0]   row_acc;
  logic          y_found;
  logic [RW-1:0] y_lo;
  logic [RW-1:0] y_hi;
  logic          drain;
  logic          vld_p1;
  logic          sv_p1;
  logic [CW-1:0] scan_addr;
  logic          issued_all;
  logic          act_prev;
  logic [CW-1:0] run_start;
  logic [CW-1:0] seg_end;
  logic          terminal;
  logic [3:0]    seg;
  logic          ovf;

  // Datapath (column RAM and read pipeline, no reset)
  logic [15:0]   col_ram [NUMBER_OF_COLS];
  logic [15:0]   rd_data_p1;
  logic [CW-1:0] addr_p1;
  logic          fg_p1;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] pix;
  logic          unused_tstrb;
  logic          tready;
  logic          xfer;
  logic          fg;
  logic [CW-1:0] pix_col;
  logic [RW-1:0] pix_row;
  logic [15:0]   line_cnt;
  logic [CW-1:0] raddr;
  logic          ram_we;
  logic [CW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;

  logic           act;
  logic           at_last;
  logic           run_open;
  logic           run_end;
  logic [CW-1:0]  cur_start;
  logic [CW-1:0]  end_col;
  logic [CW1-1:0] width;
  logic           keep;
  logic           do_write;
  logic           ovf_set;
  logic           scan_last;

  assign pix          = bus.s_axis_tdata;
  assign unused_tstrb = ^bus.s_axis_tstrb;

  assign tready            = (state == ACCUM) && !drain;
  assign bus.s_axis_tready = tready;
  assign xfer              = bus.s_axis_tvalid && tready;
  assign fg                = |pix;
  assign pix_col           = bus.s_axis_tuser ? '0 : col;
  assign pix_row           = bus.s_axis_tuser ? '0 : row;
  assign line_cnt          = sat_inc(row_acc, fg);
  assign raddr             = (state == ACCUM) ? pix_col : scan_addr;

  // Run detection on the column count returned by the previous scan read
  assign act       = sv_p1 && (rd_data_p1 >= COL_TH);
  assign at_last   = (addr_p1 == LAST_COL);
  assign run_open  = act && !act_prev;
  assign cur_start = act_prev ? run_start : addr_p1;
  assign run_end   = sv_p1 && ((act_prev && !act) || (act && at_last));
  assign end_col   = act ? addr_p1 : (addr_p1 - 1'b1);
  assign width     = {1'b0, end_col} - {1'b0, cur_start} + 1'b1;
  assign keep      = run_end && (!MIN_W_EN || (width >= MIN_W));
  assign do_write  = keep && !seg[3];
  assign ovf_set   = keep && seg[3];
  assign scan_last = sv_p1 && at_last;

  // RAM write port: zero-fill during CLEAR, otherwise the RMW write-back
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_p1;
    ram_wdata = sat_inc(rd_data_p1, fg_p1);
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end else if (vld_p1) begin
      ram_we = 1'b1;
    end
  end

  // Column RAM with 1-cycle read; read address/pixel carried to stage p1
  always_ff @(posedge aclk) begin
    if (ram_we) col_ram[ram_waddr] <= ram_wdata;
    rd_data_p1 <= col_ram[raddr];
    addr_p1    <= raddr;
    fg_p1      <= fg;
  end

  // Main FSM: clear, accumulate, scan and bound-write sequencing
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state                <= CLEAR;
      clr_addr             <= '0;
      col                  <= '0;
      row                  <= '0;
      row_acc              <= '0;
      y_found              <= 1'b0;
      y_lo                 <= '0;
      y_hi                 <= '0;
      drain                <= 1'b0;
      vld_p1               <= 1'b0;
      sv_p1                <= 1'b0;
      scan_addr            <= '0;
      issued_all           <= 1'b0;
      act_prev             <= 1'b0;
      run_start            <= '0;
      seg_end              <= '0;
      terminal             <= 1'b0;
      seg                  <= '0;
      ovf                  <= 1'b0;
      bus.bound_x_min_addr <= '0;
      bus.bound_x_min      <= '0;
      bus.bound_x_min_we   <= 1'b0;
      bus.bound_x_max_addr <= '0;
      bus.bound_x_max      <= '0;
      bus.bound_x_max_we   <= 1'b0;
      bus.bound_y_min      <= '0;
      bus.bound_y_min_we   <= 1'b0;
      bus.bound_y_max      <= '0;
      bus.bound_y_max_we   <= 1'b0;
      bus.seg_count        <= '0;
      bus.seg_overflow     <= 1'b0;
      bus.frame_done       <= 1'b0;
    end else begin
      vld_p1             <= 1'b0;
      sv_p1              <= 1'b0;
      bus.bound_x_min_we <= 1'b0;
      bus.bound_x_max_we <= 1'b0;
      bus.bound_y_min_we <= 1'b0;
      bus.bound_y_max_we <= 1'b0;
      bus.frame_done     <= 1'b0;

      case (state)
        CLEAR: begin
          clr_addr   <= clr_addr + 1'b1;
          col        <= '0;
          row        <= '0;
          row_acc    <= '0;
          y_found    <= 1'b0;
          y_lo       <= '0;
          y_hi       <= '0;
          drain      <= 1'b0;
          scan_addr  <= '0;
          issued_all <= 1'b0;
          act_prev   <= 1'b0;
          terminal   <= 1'b0;
          seg        <= '0;
          ovf        <= 1'b0;
          if (clr_addr == LAST_COL) begin
            clr_addr <= '0;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          vld_p1 <= xfer;
          if (drain) begin
            // last pixel's write-back lands this cycle
            drain <= 1'b0;
            state <= SCAN;
          end else if (xfer) begin
            if (bus.s_axis_tlast) begin
              if (line_cnt >= ROW_TH) begin
                if (!y_found) begin
                  y_found <= 1'b1;
                  y_lo    <= pix_row;
                end
                y_hi <= pix_row;
              end
              row_acc <= '0;
              col     <= '0;
              row     <= pix_row + 1'b1;
              if (pix_row == LAST_ROW) drain <= 1'b1;
            end else begin
              row_acc <= line_cnt;
              col     <= pix_col + 1'b1;
            end
          end
        end

        SCAN: begin
          // issue next read unless pausing for a bound write
          if (!issued_all && !do_write) begin
            sv_p1     <= 1'b1;
            scan_addr <= scan_addr + 1'b1;
            if (scan_addr == LAST_COL) issued_all <= 1'b1;
          end
          if (sv_p1) begin
            act_prev <= act;
            if (run_open) run_start <= addr_p1;
          end
          if (ovf_set) ovf <= 1'b1;
          if (do_write) begin
            seg_end              <= end_col;
            terminal             <= at_last;
            bus.bound_x_min_we   <= 1'b1;
            bus.bound_x_min_addr <= seg[2:0];
            bus.bound_x_min      <= 16'(cur_start);
            state                <= WR_MIN;
          end else if (scan_last) begin
            bus.bound_y_min_we <= 1'b1;
            bus.bound_y_max_we <= 1'b1;
            bus.bound_y_min    <= y_found ? 16'(y_lo) : 16'd0;
            bus.bound_y_max    <= y_found ? 16'(y_hi) : 16'd0;
            bus.seg_count      <= seg;
            bus.seg_overflow   <= ovf || ovf_set;
            bus.frame_done     <= 1'b1;
            state              <= WR_Y;
          end
        end

        WR_MIN: begin
          bus.bound_x_max_we   <= 1'b1;
          bus.bound_x_max_addr <= seg[2:0];
          bus.bound_x_max      <= 16'(seg_end);
          state                <= WR_MAX;
        end

        WR_MAX: begin
          seg <= seg + 4'd1;
          if (terminal) begin
            bus.bound_y_min_we <= 1'b1;
            bus.bound_y_max_we <= 1'b1;
            bus.bound_y_min    <= y_found ? 16'(y_lo) : 16'd0;
            bus.bound_y_max    <= y_found ? 16'(y_hi) : 16'd0;
            bus.seg_count      <= seg + 4'd1;
            bus.seg_overflow   <= ovf;
            bus.frame_done     <= 1'b1;
            state              <= WR_Y;
          end else begin
            state <= SCAN;
          end
        end

        WR_Y: begin
          state <= CLEAR;
        end

        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_char_bound_extractor.sv
// Scoreboard bench for char_bound_extractor on a reduced 64x24 frame.
// Stimulus pushes expected bound writes; a negedge monitor pops and compares.
module tb_char_bound_extractor;

  localparam int COLS = 64;
  localparam int ROWS = 24;

  localparam int K_XMIN = 0;
  localparam int K_XMAX = 1;
  localparam int K_Y    = 2;

  typedef struct {
    int kind;
    int addr;
    int d0;
    int d1;
    int cnt;
    int ovf;
  } exp_t;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  logic fd_prev = 1'b0;
  exp_t q[$];

  char_bound_extractor_if #(.C_S_AXIS_TDATA_WIDTH(8)) bus ();

  char_bound_extractor #(
    .NUMBER_OF_COLS(COLS),
    .NUMBER_OF_ROWS(ROWS),
    .C_S_AXIS_TDATA_WIDTH(8),
    .COL_THRESH(2),
    .ROW_THRESH(4),
    .MIN_CHAR_WIDTH(3)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int fid, input int r, input int c);
    bit f;
    case (fid)
      0: f = (r >= 5 && r <= 15 && ((c >= 10 && c <= 20) || (c >= 30 && c <= 50)))
             || (r == 2 && c >= 60 && c <= 62) || (r == 18 && c <= 3);
      1: f = (r == 3 || r == 4) && c >= 54;
      2: f = (r == 8 || r == 9) && c >= 2 && c <= 54 && ((c - 2) % 6) < 5;
      4: f = (r == 6 || r == 7) && ((c >= 10 && c <= 11) || (c >= 30 && c <= 40));
      5: f = (r == 10 || r == 11) && (c <= 4 || c == 63);
      default: f = 1'b0;
    endcase
    return f ? 8'(1 << (c % 8)) : 8'h00;
  endfunction

  task automatic push_x(input int a, input int lo, input int hi);
    q.push_back('{K_XMIN, a, lo, 0, 0, 0});
    q.push_back('{K_XMAX, a, hi, 0, 0, 0});
  endtask

  task automatic push_y(input int lo, input int hi, input int cnt, input int ovf);
    q.push_back('{K_Y, 0, lo, hi, cnt, ovf});
  endtask

  task automatic drive_pixel(input int fid, input int r, input int c);
    int w;
    bus.s_axis_tdata  = pix(fid, r, c);
    bus.s_axis_tuser  = (r == 0 && c == 0);
    bus.s_axis_tlast  = (c == COLS - 1);
    bus.s_axis_tvalid = 1'b1;
    w = 0;
    while (!bus.s_axis_tready && w < 5000) begin
      @(negedge aclk);
      w++;
    end
    if (w >= 5000) begin
      $display("FAIL tready_timeout: got 0 expected 1");
      $fatal(1, "tready never asserted");
    end
    @(negedge aclk);
  endtask

  task automatic idle_bus();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
  endtask

  task automatic send_frame(input int fid);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (((r * COLS + c) % 13) == 12) begin
          idle_bus();
          @(negedge aclk);
        end
        drive_pixel(fid, r, c);
      end
    end
    idle_bus();
  endtask

  task automatic wait_done(input int target);
    int w;
    w = 0;
    while (frames_done < target && w < 20 * COLS) begin
      @(negedge aclk);
      w++;
    end
    chk("frame_done_seen", frames_done, target);
    chk("queue_drained", q.size(), 0);
  endtask

  // Monitor: pop expected write for every strobe the DUT presents
  always @(negedge aclk) begin
    exp_t e;
    if (!areset) begin
      if (bus.bound_x_min_we || bus.bound_x_max_we)
        chk("strobe_overlap", int'((bus.bound_x_min_we & bus.bound_x_max_we)
            | ((bus.bound_x_min_we | bus.bound_x_max_we) & (bus.bound_y_min_we | bus.bound_y_max_we))), 0);
      if (bus.bound_x_min_we) begin
        if (q.size() == 0) chk("unexpected_xmin", 1, 0);
        else begin
          e = q.pop_front();
          chk("xmin_order", K_XMIN, e.kind);
          chk("xmin_addr", int'(bus.bound_x_min_addr), e.addr);
          chk("xmin_data", int'(bus.bound_x_min), e.d0);
        end
      end
      if (bus.bound_x_max_we) begin
        if (q.size() == 0) chk("unexpected_xmax", 1, 0);
        else begin
          e = q.pop_front();
          chk("xmax_order", K_XMAX, e.kind);
          chk("xmax_addr", int'(bus.bound_x_max_addr), e.addr);
          chk("xmax_data", int'(bus.bound_x_max), e.d0);
        end
      end
      if (bus.bound_y_min_we || bus.bound_y_max_we || bus.frame_done) begin
        if (q.size() == 0) chk("unexpected_y", 1, 0);
        else begin
          e = q.pop_front();
          chk("y_order", K_Y, e.kind);
          chk("y_min_we", int'(bus.bound_y_min_we), 1);
          chk("y_max_we", int'(bus.bound_y_max_we), 1);
          chk("frame_done", int'(bus.frame_done), 1);
          chk("y_min", int'(bus.bound_y_min), e.d0);
          chk("y_max", int'(bus.bound_y_max), e.d1);
          chk("seg_count", int'(bus.seg_count), e.cnt);
          chk("seg_overflow", int'(bus.seg_overflow), e.ovf);
        end
        frames_done++;
      end
      if (bus.frame_done && fd_prev) chk("frame_done_pulse", 1, 0);
      fd_prev = bus.frame_done;
    end else begin
      fd_prev = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tready"}, int'(bus.s_axis_tready), 0);
    chk({tag, "_strobes"}, int'({bus.bound_x_min_we, bus.bound_x_max_we,
                                 bus.bound_y_min_we, bus.bound_y_max_we, bus.frame_done}), 0);
    chk({tag, "_xdata"}, int'(bus.bound_x_min) + int'(bus.bound_x_max)
                         + int'(bus.bound_x_min_addr) + int'(bus.bound_x_max_addr), 0);
    chk({tag, "_ydata"}, int'(bus.bound_y_min) + int'(bus.bound_y_max), 0);
    chk({tag, "_status"}, int'(bus.seg_count) + int'(bus.seg_overflow), 0);
  endtask

  initial begin
    int cnt;
    bus.s_axis_tstrb = 1'b1;
    idle_bus();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check_idle_outputs("reset");
    areset = 1'b0;

    // two runs, sub-threshold noise, row at exactly ROW_THRESH
    push_x(0, 10, 20);
    push_x(1, 30, 50);
    push_y(5, 18, 2, 0);
    send_frame(0);
    wait_done(1);

    // run touching the right edge, columns at exactly COL_THRESH
    push_x(0, 54, 63);
    push_y(3, 4, 1, 0);
    send_frame(1);
    wait_done(2);

    // nine runs -> eight pairs and overflow
    for (int k = 0; k < 8; k++) push_x(k, 2 + 6 * k, 6 + 6 * k);
    push_y(8, 9, 8, 1);
    send_frame(2);
    wait_done(3);

    // empty frame
    push_y(0, 0, 0, 0);
    send_frame(3);
    wait_done(4);

    // narrow run 10..11 plus wide run 30..40
`ifdef SEG_MIN_WIDTH_EN
    push_x(0, 30, 40);
    push_y(6, 7, 1, 0);
`else
    push_x(0, 10, 11);
    push_x(1, 30, 40);
    push_y(6, 7, 2, 0);
`endif
    send_frame(4);
    wait_done(5);

    // run from column 0 and single-column run at the last column
    push_x(0, 0, 4);
`ifdef SEG_MIN_WIDTH_EN
    push_y(10, 11, 1, 0);
`else
    push_x(1, 63, 63);
    push_y(10, 11, 2, 0);
`endif
    send_frame(5);
    wait_done(6);

    // reset in the middle of accumulation
    for (int i = 0; i < 3 * COLS + 10; i++) drive_pixel(0, i / COLS, i % COLS);
    idle_bus();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    check_idle_outputs("midreset");
    @(posedge aclk);
    #1 areset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4 * COLS; i++) begin
      @(negedge aclk);
      if (bus.s_axis_tready) break;
      cnt++;
    end
    chk("clear_tready_low_cycles", cnt, COLS);
    chk("tready_after_clear", int'(bus.s_axis_tready), 1);

    // full frame after the aborted one
    push_x(0, 10, 20);
    push_x(1, 30, 50);
    push_y(5, 18, 2, 0);
    send_frame(0);
    wait_done(7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_bound_extractor.md
Name: char_bound_extractor

Overview:
- Feeds the bound-register write ports of the character reorder block (bound_x_min/max with 3-bit addr, bound_y_min/max).
- Consumes a binarized plate AXI-Stream frame and builds column and row foreground projections.
- At end of frame, scans the column projection for character runs and issues up to 8 x-bound write pairs plus one y-bound write.
- Sits between the binarization stage and the reorder block.

Parameters:
NUMBER_OF_COLS, 640, pixels per line
NUMBER_OF_ROWS, 480, lines per frame
C_S_AXIS_TDATA_WIDTH, 8, input pixel width; pixel is foreground when tdata != 0
COL_THRESH, 2, minimum foreground count for a column to belong to a character
ROW_THRESH, 4, minimum foreground count for a row to lie inside the plate
MIN_CHAR_WIDTH, 3, minimum run width in columns (used only with SEG_MIN_WIDTH_EN)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  pixel
s_axis_tstrb  in  C_S_AXIS_TDATA_WIDTH/8  ignored
s_axis_tvalid  in  1  pixel valid
s_axis_tready  out  1  accept pixel
s_axis_tlast  in  1  end of line
s_axis_tuser  in  1  start of frame
bound_x_min_addr  out  3  segment index for x-min write
bound_x_min  out  16  left column of segment
bound_x_min_we  out  1  x-min write strobe
bound_x_max_addr  out  3  segment index for x-max write
bound_x_max  out  16  right column of segment, inclusive
bound_x_max_we  out  1  x-max write strobe
bound_y_min  out  16  first plate row
bound_y_min_we  out  1  y-min write strobe
bound_y_max  out  16  last plate row, inclusive
bound_y_max_we  out  1  y-max write strobe
seg_count  out  4  segments written in last frame, 0..8
seg_overflow  out  1  last frame contained more than 8 runs
frame_done  out  1  one-cycle pulse after final write of a frame

Behaviour:
- Reset: all outputs 0; FSM enters CLEAR.
- Column RAM: NUMBER_OF_COLS x 16-bit, simple dual-port, 1-cycle read latency. Read-modify-write is pipelined. Consecutive accepted pixels always address different columns, so no forwarding is needed.
- FSM states: CLEAR, ACCUM, SCAN, WR_MIN, WR_MAX, WR_Y.
- CLEAR:
  - tready=0.
  - Write 0 to column 0..NUMBER_OF_COLS-1, one per cycle.
  - Reset row/col counters, row-count accumulator, y_first/y_last flags, seg index, overflow.
  - Then go to ACCUM.
- ACCUM:
  - tready=1.
  - A transfer is tvalid&tready.
  - tuser on a transfer forces col=0, row=0 for that pixel, which resyncs the frame. Already-accumulated counts are kept.
  - Each transfer: column count += (tdata!=0), saturating at 0xFFFF; row accumulator += (tdata!=0); col++.
  - On tlast: row qualifies if its count >= ROW_THRESH. The first qualifying row sets y_min; every qualifying row updates y_max. Then row++, col=0, row accumulator=0.
  - tlast with row==NUMBER_OF_ROWS-1: go to SCAN after the pipeline drains (1 cycle).
  - tlast is authoritative for line end. col is not compared against NUMBER_OF_COLS.
- SCAN:
  - tready=0.
  - Read columns 0..NUMBER_OF_COLS-1 in order; active = count >= COL_THRESH.
  - Inactive->active: start=col.
  - Active->inactive at col c: end=c-1.
  - Active at col NUMBER_OF_COLS-1: end=NUMBER_OF_COLS-1.
  - On run end, if seg<8: pause the scan address and go to WR_MIN. If seg==8: set seg_overflow, no write.
  - After the last column, go to WR_Y.
- WR_MIN: bound_x_min_we=1 for 1 cycle, addr=seg, data=start. Go to WR_MAX.
- WR_MAX:
  - bound_x_max_we=1 for 1 cycle, addr=seg, data=end; seg++.
  - Resume SCAN at the next column. A terminal run at the last column goes to WR_Y.
- WR_Y:
  - bound_y_min_we and bound_y_max_we both 1 for 1 cycle.
  - If no row qualified: y_min=y_max=0.
  - seg_count=seg; frame_done=1 the same cycle.
  - Go to CLEAR.
- Data outputs hold their last written value between strobes. Strobes are never asserted together except the y pair.
- areset mid-frame: any partial frame is discarded and no writes are issued. Restart in CLEAR.

Optional Feature:
- Macro SEG_MIN_WIDTH_EN.
- Defined: runs with (end-start+1) < MIN_CHAR_WIDTH are dropped with no write. They are not counted in seg and do not set seg_overflow.
- Undefined: every run of width >=1 is written.

Test Plan:
- Reset: assert areset mid-ACCUM -> all strobes/outputs 0; tready=0 for exactly 640 cycles, then 1.
- Frame with foreground columns 10..20 and 30..50 on rows 100..200, 10 px each column-row cell, thresholds default:
  - x_min addr0=10, then x_max addr0=20;
  - x_min addr1=30, x_max addr1=50;
  - y 100/200 written together;
  - seg_count=2, frame_done one pulse.
- Run 630..639 touching the right edge -> x_min=630, x_max=639 written before WR_Y.
- Nine 5-column runs separated by gaps -> exactly 8 write pairs (addr 0..7), seg_count=8, seg_overflow=1.
- All-zero frame -> no x writes; y_min=y_max=0 written; seg_count=0.
- With SEG_MIN_WIDTH_EN: runs 10..11 and 30..40 -> only addr0=30/40 written, seg_count=1. Without the macro -> two segments written.
